// File: rtl/linear_layer_start_token_fifo.sv
// linear_layer_start_token_fifo: shift-register start-token FIFO with first-word fall-through.
// The newest token enters at sr_q[0]; the oldest sits at sr_q[count_q-1].
module linear_layer_start_token_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   if_num_data_valid
);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] sr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  push, pop;

    assign if_empty_n        = count_q != '0;
    assign if_full_n         = count_q != CNT_FULL;
    assign if_num_data_valid = count_q;
    assign push              = if_write & if_write_ce & if_full_n;
    assign pop               = if_read & if_read_ce & if_empty_n;
    // Wraps harmlessly when empty; dout is a don't-care then.
    assign rd_addr           = ADDR_WIDTH'(count_q - CNT_ONE);
    assign if_dout           = sr_q[rd_addr];

    always_comb begin
        count_d = (push && !pop) ? count_q + CNT_ONE :
                  (pop && !push) ? count_q - CNT_ONE : count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            sr_q[0] <= if_din;
            for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end
endmodule

// File: tb/tb_linear_layer_start_token_fifo.sv
// tb_linear_layer_start_token_fifo: directed and random stimulus against a queue-based FIFO model.
module tb_linear_layer_start_token_fifo;
    localparam int DW = 8;
    localparam int AW = 1;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_full_n, if_empty_n;
    logic          if_write_ce = 1'b0, if_write = 1'b0, if_read_ce = 1'b0, if_read = 1'b0;
    logic [DW-1:0] if_din = '0, if_dout;
    logic [AW:0]   if_num_data_valid;

    int            n_tests = 0;
    int            n_fail = 0;
    logic [DW-1:0] model_q[$];
    bit            model_valid = 1'b0;

    always #5 clk = ~clk;

    linear_layer_start_token_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .if_full_n(if_full_n), .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
        .if_empty_n(if_empty_n), .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout),
        .if_num_data_valid(if_num_data_valid)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive, compare against model state, then advance the model across the edge.
    task automatic step(input bit rst, input bit wce, input bit w, input logic [DW-1:0] d,
                        input bit rce, input bit r);
        bit do_push, do_pop;
        reset = rst; if_write_ce = wce; if_write = w; if_din = d; if_read_ce = rce; if_read = r;
        @(negedge clk);
        if (model_valid) begin
            check("num", int'(if_num_data_valid), model_q.size());
            check("empty_n", int'(if_empty_n), int'(model_q.size() != 0));
            check("full_n", int'(if_full_n), int'(model_q.size() != DEPTH));
            if (model_q.size() != 0) check("dout", int'(if_dout), int'(model_q[0]));
        end
        do_push = wce && w && model_q.size() < DEPTH;
        do_pop  = rce && r && model_q.size() > 0;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            model_valid = 1'b1;
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
        end
        #1;
    endtask

    task automatic idle();
        step(0, 1, 0, '0, 1, 0);
    endtask

    initial begin
        step(1, 0, 0, '0, 0, 0);
        step(1, 0, 0, '0, 0, 0);
        idle();
        // fill, drain
        step(0, 1, 1, 8'hA1, 1, 0);
        step(0, 1, 1, 8'hB2, 1, 0);
        idle();
        step(0, 1, 0, '0, 1, 1);
        step(0, 1, 0, '0, 1, 1);
        idle();
        // write while full is dropped
        step(0, 1, 1, 8'hA1, 1, 0);
        step(0, 1, 1, 8'hB2, 1, 0);
        step(0, 1, 1, 8'hC3, 1, 0);
        step(0, 1, 0, '0, 1, 1);
        step(0, 1, 0, '0, 1, 1);
        idle();
        // full with pop+push: pop completes, push blocked
        step(0, 1, 1, 8'h44, 1, 0);
        step(0, 1, 1, 8'h55, 1, 0);
        step(0, 1, 1, 8'h66, 1, 1);
        step(0, 1, 0, '0, 1, 1);
        idle();
        // simultaneous push+pop at count 1
        step(0, 1, 1, 8'h11, 1, 0);
        step(0, 1, 1, 8'h22, 1, 1);
        idle();
        step(0, 1, 0, '0, 1, 1);
        // empty with read+write
        step(0, 1, 1, 8'h33, 1, 1);
        idle();
        // reset mid-stream with requests high
        step(0, 1, 1, 8'h77, 1, 0);
        step(1, 1, 1, 8'h88, 1, 1);
        idle();
        // CE masking on each side
        step(0, 0, 1, 8'h99, 1, 0);
        step(0, 1, 1, 8'h5A, 1, 0);
        step(0, 1, 0, '0, 0, 1);
        idle();
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 63) == 0), $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                 DW'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0);
        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
